urv_trap_unit: RTL
==================

// Module: urv_trap_unit
// PURPOSE
//  Machine-mode trap state owner for uRV: holds mstatus/mie/mip/mepc/mcause, consumes CSR write values
//  from the CSR datapath (x_csr_write_value), exports architectural CSR values to the CSR read mux.
//  Sequences exception entry, interrupt entry and mret; raises interrupt request to the pipeline.
// PARAMETERS
//  TRAP_VECTOR  32'h0000_0008  redirect PC for every trap (exception or interrupt)
// PORTS
//  clk_i                in   1   system clock
//  rst_i                in   1   asynchronous reset, active low
//  x_stall_i            in   1   execute stage stalled; no state update
//  x_kill_i             in   1   execute instruction killed; no state update
//  d_is_csr_i           in   1   instruction in execute is a CSR op
//  d_csr_sel_i          in   12  CSR address of that op
//  x_csr_write_value_i  in   32  new CSR value computed by CSR datapath
//  x_exception_i        in   1   synchronous exception in execute
//  x_exception_cause_i  in   4   exception code (mcause[3:0])
//  x_exception_pc_i     in   32  PC of faulting/interrupted instruction
//  x_take_irq_i         in   1   pipeline accepts pending interrupt at this instruction boundary
//  x_is_mret_i          in   1   mret in execute
//  irq_i                in   1   external interrupt line, level, synchronous to clk_i
//  csr_time_i           in   40  free-running time counter
//  x_trap_o             out  1   redirect: trap entry (pc=TRAP_VECTOR) or mret (pc=mepc), 1 cycle
//  x_trap_pc_o          out  32  redirect target, valid with x_trap_o
//  x_irq_o              out  1   interrupt pending and enabled (registered)
//  csr_mstatus_o/mip_o/mie_o/mepc_o/mcause_o  out 32 each  architectural values
//  csr_mtimecmp_o       out  40  timer compare value (0 when feature compiled out)
// BEHAVIOUR
//  - Reset: MIE=MPIE=0, mie=0, MEIP/MTIP=0, mepc=0, mcause=0, x_trap_o=0, x_trap_pc_o=0, x_irq_o=0, mtimecmp=all ones.
//  - "valid" = !x_stall_i && !x_kill_i; all updates at posedge when valid, outputs visible next cycle.
//  - mstatus: bit3 MIE, bit7 MPIE, others read 0, writes ignored. mie: bit11 MEIE, bit7 MTIE only.
//  - mip: MEIP(bit11) = irq_i registered 1 cycle; MTIP(bit7) per CONFIGURATION; mip writes ignored.
//  - CSR write: valid && d_is_csr_i && sel matches -> register <= x_csr_write_value_i; mepc[1:0] forced 0.
//  - Exception (valid && x_exception_i): mepc<=pc&~3, mcause<={28'h0,cause}, MPIE<=MIE, MIE<=0,
//    x_trap_o=1, x_trap_pc_o=TRAP_VECTOR next cycle.
//  - x_irq_o <= MIE && |(mip & mie), registered; drops the cycle after MIE clears.
//  - Interrupt entry (valid && x_take_irq_i && x_irq_o): as exception, mcause = 32'h8000_000B if
//    MEIP&MEIE, else 32'h8000_0007 (external has priority over timer).
//  - mret (valid && x_is_mret_i): MIE<=MPIE, MPIE<=1, x_trap_o=1, x_trap_pc_o=mepc (pre-update value).
//  - Priority same cycle: exception > interrupt entry > mret > CSR write for mstatus/mepc/mcause;
//    losing interrupt stays pending. CSR write to mie/mtimecmp still applied alongside any trap.
//  - x_take_irq_i with x_irq_o=0 ignored. Stalled/killed cycles: no change, x_trap_o=0.
//  - Reset mid-trap: all state cleared immediately (async), no redirect issued.
// CONFIGURATION
//  URV_TRAP_MTIMECMP_EN defined: 40-bit mtimecmp at CSR_ID_MTIMECMPL (bits 31:0) / CSR_ID_MTIMECMPH
//    (bits 39:32, upper 24 read 0); MTIP = (csr_time_i >= mtimecmp), registered; writing mtimecmp
//    clears MTIP next cycle when new value > time.
//  Not defined: MTIP=0, mie.MTIE reads 0, csr_mtimecmp_o=0, mtimecmp CSR ids ignored.
// STRUCTURE
//  urv_defs.v: CSR_ID_MSTATUS/MIE/MIP/MEPC/MCAUSE, new CSR_ID_MTIMECMPL/H, bit positions
//  MSTATUS_MIE/MPIE, MIE_MEIE/MTIE, cause codes CAUSE_IRQ_EXT/TIMER.
//  One sub-module: urv_timer_cmp (mtimecmp register + comparator), instantiated only under the macro.
// TESTING
//  1 Reset, read all csr_*_o -> zeros (mtimecmp all ones with macro); x_irq_o=0, x_trap_o=0.
//  2 CSR write mstatus=0x88 then exception cause 2 pc 0x103 -> mepc=0x100, mcause=2, mstatus=0x80, redirect 0x8.
//  3 mie=0x800, MIE=1, irq_i=1 -> x_irq_o=1 two cycles later; take_irq pc 0x40 -> mcause=0x8000000B, x_irq_o=0.
//  4 mret with mepc=0x40, MPIE=1 -> x_trap_pc_o=0x40, mstatus=0x88; stalled mret -> no change.
//  5 Exception and take_irq same cycle -> mcause=exception code, x_irq_o reasserts after mret.
//  6 (macro) mtimecmp=100, MTIE=1, MIE=1, time 99->100 -> MTIP=1, x_irq_o next cycle; mcause=0x80000007.

Source files
------------

// File: rtl/urv_trap_unit_pkg.sv
// CSR addresses, bit positions and cause codes shared by the uRV trap unit and its timer compare.
package urv_trap_unit_pkg;

  localparam logic [11:0] CSR_ID_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_ID_MIE       = 12'h304;
  localparam logic [11:0] CSR_ID_MEPC      = 12'h341;
  localparam logic [11:0] CSR_ID_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_ID_MIP       = 12'h344;
  localparam logic [11:0] CSR_ID_MTIMECMPL = 12'h7C0;
  localparam logic [11:0] CSR_ID_MTIMECMPH = 12'h7C1;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  // mip uses the same bit positions as mie
  localparam int MIE_MEIE     = 11;
  localparam int MIE_MTIE     = 7;

  localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;
  localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;

  function automatic logic [31:0] irq_cause(input logic [3:0] code);
    return {1'b1, 27'h0, code};
  endfunction

endpackage

// File: rtl/urv_timer_cmp.sv
// 40-bit mtimecmp register and comparator, built only with URV_TRAP_MTIMECMP_EN.
// MTIP is registered against the post-write compare value, so a new compare takes effect next cycle.
`ifdef URV_TRAP_MTIMECMP_EN
module urv_timer_cmp (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [39:0] time_i,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [39:0] mtimecmp,
  output logic        mtip
);

  logic [39:0] cmp_nxt;

  always_comb begin
    cmp_nxt = mtimecmp;
    if (wr_lo) cmp_nxt[31:0]  = wdata;
    if (wr_hi) cmp_nxt[39:32] = wdata[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mtimecmp <= '1;
      mtip     <= 1'b0;
    end else begin
      mtimecmp <= cmp_nxt;
      mtip     <= (time_i >= cmp_nxt);
    end
  end

endmodule
`endif

// File: rtl/urv_trap_unit.sv
// Machine-mode trap state (mstatus/mie/mip/mepc/mcause); optional mtimecmp via URV_TRAP_MTIMECMP_EN.
// Updates land one cycle after a valid execute slot; stall or kill freezes state and suppresses redirect.
module urv_trap_unit
  import urv_trap_unit_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0008
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic        d_is_csr_i,
  input  logic [11:0] d_csr_sel_i,
  input  logic [31:0] x_csr_write_value_i,
  input  logic        x_exception_i,
  input  logic [3:0]  x_exception_cause_i,
  input  logic [31:0] x_exception_pc_i,
  input  logic        x_take_irq_i,
  input  logic        x_is_mret_i,
  input  logic        irq_i,
  input  logic [39:0] csr_time_i,
  output logic        x_trap_o,
  output logic [31:0] x_trap_pc_o,
  output logic        x_irq_o,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o,
  output logic [39:0] csr_mtimecmp_o
);

  logic        valid, exc, irq_entry, mret, trap_entry;
  logic        we_mstatus, we_mie, we_mepc, we_mcause;
  logic        st_mie, st_mpie, meie, mtie, meip, mtip;
  logic [31:0] mepc, mcause;

  assign valid      = !x_stall_i && !x_kill_i;
  assign exc        = valid && x_exception_i;
  // A pending interrupt that loses to an exception is simply retaken later
  assign irq_entry  = valid && x_take_irq_i && x_irq_o && !exc;
  assign mret       = valid && x_is_mret_i && !exc && !irq_entry;
  assign trap_entry = exc || irq_entry;

  assign we_mstatus = valid && d_is_csr_i && (d_csr_sel_i == CSR_ID_MSTATUS);
  assign we_mie     = valid && d_is_csr_i && (d_csr_sel_i == CSR_ID_MIE);
  assign we_mepc    = valid && d_is_csr_i && (d_csr_sel_i == CSR_ID_MEPC);
  assign we_mcause  = valid && d_is_csr_i && (d_csr_sel_i == CSR_ID_MCAUSE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st_mie      <= 1'b0;
      st_mpie     <= 1'b0;
      meie        <= 1'b0;
      meip        <= 1'b0;
      mepc        <= '0;
      mcause      <= '0;
      x_trap_o    <= 1'b0;
      x_trap_pc_o <= '0;
      x_irq_o     <= 1'b0;
    end else begin
      meip     <= irq_i;
      x_irq_o  <= st_mie && |(csr_mip_o & csr_mie_o);
      x_trap_o <= trap_entry || mret;
      if (trap_entry) begin
        st_mpie     <= st_mie;
        st_mie      <= 1'b0;
        mepc        <= {x_exception_pc_i[31:2], 2'b00};
        x_trap_pc_o <= TRAP_VECTOR;
        if (exc)
          mcause <= {28'h0, x_exception_cause_i};
        else if (meip && meie)
          mcause <= irq_cause(CAUSE_IRQ_EXT);
        else
          mcause <= irq_cause(CAUSE_IRQ_TIMER);
      end else if (mret) begin
        st_mie      <= st_mpie;
        st_mpie     <= 1'b1;
        x_trap_pc_o <= mepc;
      end else begin
        if (we_mstatus) begin
          st_mie  <= x_csr_write_value_i[MSTATUS_MIE];
          st_mpie <= x_csr_write_value_i[MSTATUS_MPIE];
        end
        if (we_mepc)   mepc   <= {x_csr_write_value_i[31:2], 2'b00};
        if (we_mcause) mcause <= x_csr_write_value_i;
      end
      // mie is not touched by trap sequencing, so its write always lands
      if (we_mie) meie <= x_csr_write_value_i[MIE_MEIE];
    end
  end

`ifdef URV_TRAP_MTIMECMP_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      mtie <= 1'b0;
    else if (we_mie) mtie <= x_csr_write_value_i[MIE_MTIE];
  end

  urv_timer_cmp u_timer_cmp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .time_i   (csr_time_i),
    .wr_lo    (valid && d_is_csr_i && (d_csr_sel_i == CSR_ID_MTIMECMPL)),
    .wr_hi    (valid && d_is_csr_i && (d_csr_sel_i == CSR_ID_MTIMECMPH)),
    .wdata    (x_csr_write_value_i),
    .mtimecmp (csr_mtimecmp_o),
    .mtip     (mtip)
  );
`else
  logic unused_time;
  assign unused_time    = ^csr_time_i;
  assign mtie           = 1'b0;
  assign mtip           = 1'b0;
  assign csr_mtimecmp_o = '0;
`endif

  always_comb begin
    csr_mstatus_o               = '0;
    csr_mstatus_o[MSTATUS_MIE]  = st_mie;
    csr_mstatus_o[MSTATUS_MPIE] = st_mpie;
    csr_mie_o                   = '0;
    csr_mie_o[MIE_MEIE]         = meie;
    csr_mie_o[MIE_MTIE]         = mtie;
    csr_mip_o                   = '0;
    csr_mip_o[MIE_MEIE]         = meip;
    csr_mip_o[MIE_MTIE]         = mtip;
  end

  assign csr_mepc_o   = mepc;
  assign csr_mcause_o = mcause;

endmodule
